nibble_serial_add_ctrl: RTL and testbench



---
 rtl/nibble_serial_add_ctrl_pkg.sv | 13 +
 rtl/nibble_serial_add_ctrl_if.sv | 29 ++
 rtl/nibble_serial_add_ctrl_slice.sv | 29 ++
 rtl/nibble_serial_add_ctrl.sv | 103 ++++++++++
 tb/tb_nibble_serial_add_ctrl.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial carry-skip adder controller.
package csa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {IDLE, RUN, DONE} add_state_t;

    // Counter must hold every value 0..nib inclusive.
    function automatic int skip_cnt_w(input int nib);
        return $clog2(nib + 1);
    endfunction

endpackage

// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle between producer/consumer and the adder controller.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    localparam int CNT_W = csa_pkg::skip_cnt_w(WIDTH / csa_pkg::NIBBLE_W);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CNT_W-1:0] skip_cnt;
    logic             busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, skip_cnt, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, skip_cnt, busy
    );

endinterface

// File: rtl/nibble_serial_add_ctrl_slice.sv
// Combinational 4-bit carry-skip slice: ripple chain with a bypass of the
// incoming carry when every bit propagates.
module csa4_slice
    import csa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co,
    output logic                p
);
    logic [NIBBLE_W-1:0] w_t;
    logic [NIBBLE_W:0]   w_c;

    always_comb begin
        w_t = a ^ b;
        s   = '0;
        w_c = '0;
        w_c[0] = ci;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]     = w_t[i] ^ w_c[i];
            w_c[i+1] = (a[i] & b[i]) | (w_t[i] & w_c[i]);
        end
        p  = &w_t;
        co = p ? ci : w_c[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Adds two WIDTH-bit operands one nibble per clock through a single shared
// carry-skip slice, LSB nibble first, behind valid/ready handshakes.
module nibble_serial_add_ctrl
    import csa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                    clk,
    input logic                    rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = skip_cnt_w(NIB);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    add_state_t          r_state;
    add_state_t          w_state_nxt;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic                r_carry;
    logic [IDX_W-1:0]    r_idx;
    logic [CNT_W-1:0]    r_skip;
    logic                w_accept;
    logic                w_last;
    logic [NIBBLE_W-1:0] w_sa;
    logic [NIBBLE_W-1:0] w_sb;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_co;
    logic                w_p;

    assign w_sa   = r_a[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_sb   = r_b[NIBBLE_W*r_idx +: NIBBLE_W];
    assign w_last = (r_idx == IDX_W'(NIB - 1));

    csa4_slice u_slice (
        .a  (w_sa),
        .b  (w_sb),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co),
        .p  (w_p)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // DONE returns to IDLE before accepting again, so handoff and accept never share a cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_accept      = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                w_accept     = bus.in_valid;
                if (bus.in_valid) w_state_nxt = RUN;
            end
            RUN: begin
                bus.busy = 1'b1;
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_skip  <= '0;
        end else if (w_accept) begin
            r_a     <= bus.a;
            r_b     <= bus.b;
            r_carry <= bus.cin;
            r_idx   <= '0;
            r_skip  <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            r_sum[NIBBLE_W*r_idx +: NIBBLE_W] <= w_s;
            r_carry <= w_co;
            r_skip  <= r_skip + CNT_W'(w_p);
            if (!w_last) r_idx <= r_idx + 1'b1;
        end
    end

    assign bus.sum      = r_sum;
    assign bus.cout     = r_carry;
    assign bus.skip_cnt = r_skip;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Scoreboard bench for nibble_serial_add_ctrl: directed operands, expected
// results queued at issue and checked by an independent output monitor.
module tb_nibble_serial_add_ctrl;
    import csa_pkg::*;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = skip_cnt_w(NIB);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic [CNT_W-1:0] skip;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    nibble_serial_add_ctrl_if #(.WIDTH(WIDTH)) bif ();

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk   = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   acc_cyc = -100;
    logic prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [WIDTH-1:0] s, input logic c, input int k);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.skip = CNT_W'(k);
        return e;
    endfunction

    // Output monitor: latency on each rising out_valid, data on each handoff.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            if (bif.in_valid && bif.in_ready) acc_cyc = cyc;
            if (bif.out_valid && !prev_ov) chk("latency", cyc - acc_cyc, NIB + 1);
            if (bif.out_valid && bif.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("sum",      bif.sum,      mon_e.sum);
                    chk("cout",     bif.cout,     mon_e.cout);
                    chk("skip_cnt", bif.skip_cnt, mon_e.skip);
                end
            end
            prev_ov = bif.out_valid;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic cin, input bit push, input exp_t e);
        int t;
        bif.in_valid = 1'b1;
        bif.a        = a;
        bif.b        = b;
        bif.cin      = cin;
        if (push) sb.push_back(e);
        t = 0;
        while (!bif.in_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bif.in_ready) chk("accept_timeout", bif.in_ready, 1);
        tick();
        bif.in_valid = 1'b0;
        bif.a        = '1;
        bif.b        = '1;
        bif.cin      = 1'b1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || !bif.in_ready) && t < 200) begin
            tick();
            t++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  bif.in_ready,  1);
        chk({tag, "_out_valid"}, bif.out_valid, 0);
        chk({tag, "_busy"},      bif.busy,      0);
        chk({tag, "_sum"},       bif.sum,       0);
        chk({tag, "_cout"},      bif.cout,      0);
        chk({tag, "_skip_cnt"},  bif.skip_cnt,  0);
    endtask

    initial begin
        int   t;
        logic seen;
        bif.in_valid  = 1'b0;
        bif.a         = '0;
        bif.b         = '0;
        bif.cin       = 1'b0;
        bif.out_ready = 1'b1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk_reset_vals("reset");
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        send(16'h1234, 16'h4321, 1'b0, 1, mk(16'h5555, 1'b0, 0));
        drain();
        send(16'hFFFF, 16'h0000, 1'b1, 1, mk(16'h0000, 1'b1, 4));
        drain();
        send(16'h0F0F, 16'hF0F0, 1'b0, 1, mk(16'hFFFF, 1'b0, 4));
        drain();
        send(16'h8000, 16'h8000, 1'b0, 1, mk(16'h0000, 1'b1, 0));
        drain();

        // Backpressure, with a new operand waiting across the handoff.
        bif.out_ready = 1'b0;
        send(16'h1111, 16'h2222, 1'b0, 1, mk(16'h3333, 1'b0, 0));
        t = 0;
        while (!bif.out_valid && t < 50) begin
            tick();
            t++;
        end
        chk("bp_out_valid", bif.out_valid, 1);
        bif.in_valid = 1'b1;
        bif.a        = 16'h0005;
        bif.b        = 16'h0006;
        bif.cin      = 1'b0;
        sb.push_back(mk(16'h000B, 1'b0, 0));
        for (int k = 0; k < 3; k++) begin
            chk("bp_sum",      bif.sum,       16'h3333);
            chk("bp_cout",     bif.cout,      0);
            chk("bp_skip_cnt", bif.skip_cnt,  0);
            chk("bp_in_ready", bif.in_ready,  0);
            chk("bp_busy",     bif.busy,      1);
            chk("bp_hold",     bif.out_valid, 1);
            tick();
        end
        bif.out_ready = 1'b1;
        tick();
        chk("handoff_out_valid", bif.out_valid, 0);
        chk("handoff_in_ready",  bif.in_ready,  1);
        tick();
        bif.in_valid = 1'b0;
        drain();

        // Inputs change right after acceptance.
        send(16'hAAAA, 16'h5555, 1'b0, 1, mk(16'hFFFF, 1'b0, 4));
        drain();

        // Abort in the second RUN cycle.
        send(16'h1234, 16'h000B, 1'b0, 0, mk(16'h0000, 1'b0, 0));
        tick();
        chk("pre_abort_busy", bif.busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("abort");
        tick();
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            seen |= bif.out_valid;
            tick();
        end
        chk("abort_no_valid", seen, 0);

        send(16'h0001, 16'h0001, 1'b0, 1, mk(16'h0002, 1'b0, 0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
